spi_sram_ctrl: RTL
==================

// Module: spi_sram_ctrl
// PURPOSE
//   Memory-mapped SPI SRAM controller on the FemtoRV32 data bus, selected by the dpRAM chip-select (0x0001xxxx).
//   Turns one word read/write strobe into a single SPI mode-0 transaction (READ 0x03 / WRITE 0x02) to an external SRAM.
//   Holds the CPU with rbusy/wbusy until the transfer completes.
//   Returns the word little-endian on rdata.
// PARAMETERS
//   DIV  1  SCK half-period in clk cycles (SCK = clk/(2*DIV)); legal 1..255
// PORTS
//   clk           in   1   system clock (25 MHz)
//   rst           in   1   asynchronous, active-high reset
//   word_address  in   20  word address (mem_addr[21:2])
//   wdata         in   32  write word; byte 0 = wdata[7:0]
//   rd            in   1   read strobe, one cycle, already qualified by chip-select
//   wr            in   1   write strobe, one cycle, already qualified by chip-select; full-word write only
//   rdata         out  32  read word, valid from the cycle rbusy falls, held until the next read completes
//   rbusy         out  1   read in progress
//   wbusy         out  1   write in progress
//   CLK           out  1   SPI SCK, idles low
//   CS_N          out  1   SPI chip select, active low
//   MOSI          out  1   SPI data to SRAM
//   MISO          in   1   SPI data from SRAM
// BEHAVIOUR
//   Reset values: CS_N=1, CLK=0, MOSI=0, rbusy=0, wbusy=0, rdata=0, state=IDLE.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE
//     - Samples rd/wr.
//     - wr=1: loads a 64-bit shift register {8'h02, 2'b00, word_address, 2'b00, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}.
//     - rd=1: loads {8'h03, 2'b00, word_address, 2'b00, 32'h0}; MOSI is 0 during the data phase.
//     - rd and wr in the same cycle: wr wins, rd is dropped, rbusy stays 0.
//   SHIFT
//     - The cycle after the strobe: CS_N=0, busy flag=1, MOSI = shift[63], CLK=0.
//     - Each bit is DIV cycles with CLK low, then DIV cycles with CLK high.
//     - MISO is sampled into the receive register on the clk edge that raises CLK.
//     - MOSI advances to the next bit on the clk edge that lowers CLK.
//     - A 7-bit bit counter runs 0..63. After the high half of bit 63, CLK=0 and the state goes to DONE.
//   DONE (1 cycle)
//     - CS_N=1 and the busy flag is still 1.
//     - For reads, rdata is loaded with {rx[7:0], rx[15:8], rx[23:16], rx[31:24]}, where rx[31:24] is the first byte received.
//     - Next state is IDLE with the busy flag=0.
//   Latency: busy is high for exactly 128*DIV+1 cycles. rdata is updated on the edge where rbusy falls.
//   CS_N returns high for at least 1 cycle between transactions; a back-to-back strobe in IDLE starts immediately.
//   Strobes arriving while not in IDLE are ignored; the CPU never issues them because it stalls on busy.
//   rbusy and wbusy are never high together.
//   The SPI signals are registered outputs, so there are no glitches on CLK/CS_N.
//   Reset mid-transfer (asynchronous):
//     - CS_N=1 and CLK=0 immediately; busy is cleared and rdata=0.
//     - The aborted write is not completed.
//   Byte address sent = {2'b00, word_address, 2'b00} (24-bit, MSB first). The address wraps only inside the SRAM.
// TESTING
//   1. DIV=1, wr word_address=0x00010, wdata=0xDEADBEEF
//      -> MOSI bytes 02 00 00 40 EF BE AD DE; wbusy high for 129 cycles; 64 CLK rising edges; CS_N low for 128 cycles.
//   2. DIV=1, rd word_address=0x00010, SRAM model drives 11 22 33 44 in the data phase
//      -> MOSI bytes 03 00 00 40; rbusy high for 129 cycles; rdata=0x44332211 in the cycle rbusy falls.
//   3. DIV=3, rd at word 0xFFFFF
//      -> address bytes 3F FF FC; CLK period 6 cycles; rbusy high for 385 cycles.
//   4. rd and wr pulsed in the same cycle
//      -> write transaction only; rbusy stays 0.
//   5. Extra rd pulse mid-transfer
//      -> ignored; exactly 64 CLK edges; a single transaction.
//   6. rst asserted at bit 20 of a write
//      -> CS_N=1, CLK=0, wbusy=0 immediately; after release, a new rd completes normally with correct rdata.

Source files
------------

// File: rtl/spi_sram_ctrl.sv
// SPI mode-0 SRAM controller: one CPU word read/write becomes one 64-bit
// READ (0x03) / WRITE (0x02) transaction. The CPU is stalled on rbusy/wbusy.
module spi_sram_ctrl #(
    parameter int unsigned DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] word_address,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        rbusy,
    output logic        wbusy,
    output logic        CLK,
    output logic        CS_N,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_shift;
    logic [31:0] r_rx;
    logic [6:0]  r_bit;
    logic [7:0]  r_div;

    logic        w_start;
    logic        w_half_end;
    logic        w_last;
    logic [63:0] w_frame;

    assign w_start    = rd | wr;
    assign w_half_end = (r_div == 8'(DIV - 1));
    assign w_last     = w_half_end & CLK & (r_bit == 7'd63);

    // Write data goes out byte 0 first; a read shifts zeros during the data phase.
    assign w_frame = wr ? {8'h02, 2'b00, word_address, 2'b00,
                           wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}
                        : {8'h03, 2'b00, word_address, 2'b00, 32'h0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = SHIFT;
            SHIFT:   if (w_last)  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_rx    <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            rdata   <= '0;
            rbusy   <= 1'b0;
            wbusy   <= 1'b0;
            CLK     <= 1'b0;
            CS_N    <= 1'b1;
            MOSI    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shift <= w_frame;
                        MOSI    <= w_frame[63];
                        CS_N    <= 1'b0;
                        CLK     <= 1'b0;
                        r_bit   <= '0;
                        r_div   <= '0;
                        wbusy   <= wr;
                        rbusy   <= ~wr;
                    end
                end
                SHIFT: begin
                    if (!w_half_end) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div <= '0;
                        if (!CLK) begin
                            CLK  <= 1'b1;
                            r_rx <= {r_rx[30:0], MISO};
                        end else begin
                            CLK <= 1'b0;
                            if (r_bit == 7'd63) begin
                                CS_N <= 1'b1;
                                MOSI <= 1'b0;
                            end else begin
                                r_shift <= {r_shift[62:0], 1'b0};
                                MOSI    <= r_shift[62];
                                r_bit   <= r_bit + 7'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    // First received byte is the lowest-addressed one, i.e. rdata[7:0].
                    if (rbusy) begin
                        rdata <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                    end
                    rbusy <= 1'b0;
                    wbusy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
